// File: rtl/prog_feeder.sv
// prog_feeder: program store and sequencer for the datapath processor.
// Holds a write-loaded program, presents one instruction (plus an MVI
// immediate) at a time on DIN with a one-cycle Run strobe, and waits on
// Done with a watchdog before moving on.
module prog_feeder #(
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int TIMEOUT = 15
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Go,
  input  logic          WrEn,
  input  logic [AW-1:0] WrAddr,
  input  logic [15:0]   WrData,
  input  logic          Done,
  output logic [15:0]   DIN,
  output logic          Run,
  output logic          Busy,
  output logic          Halted,
  output logic          Error,
  output logic [AW-1:0] PC,
  output logic [15:0]   InstrCount
);

  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;
  localparam int         WDW     = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] ADV1   = (AW+1)'(1);
  localparam logic [AW:0] ADV2   = (AW+1)'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_HALTED
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [15:0]     r_mem [DEPTH];
  logic [15:0]     r_din, w_din_nxt;
  logic            r_run, w_run_nxt;
  logic [AW-1:0]   r_pc, w_pc_nxt;
  logic [15:0]     r_cnt, w_cnt_nxt;
  logic            r_err, w_err_nxt;
  logic            r_mvi, w_mvi_nxt;
  logic [WDW-1:0]  r_wd, w_wd_nxt;

  logic [15:0]     w_word;
  logic [15:0]     w_imm;
  logic [AW:0]     w_adv;
  logic            w_can_load;
  logic            w_wd_fire;

  // Current word, its successor (MVI immediate) and the PC advance with carry.
  assign w_word     = r_mem[r_pc];
  assign w_imm      = r_mem[r_pc + AW'(1)];
  assign w_adv      = {1'b0, r_pc} + (r_mvi ? ADV2 : ADV1);
  assign w_can_load = (r_state == S_IDLE) || (r_state == S_HALTED);
  assign w_wd_fire  = (r_wd == WDW'(TIMEOUT - 1));

  // Program store: writable only while the sequencer is parked; not reset.
  always_ff @(posedge Clock) begin
    if (WrEn && w_can_load) begin
      r_mem[WrAddr] <= WrData;
    end
  end

  // State and datapath registers; everything returns to idle values on reset.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= S_IDLE;
      r_din   <= '0;
      r_run   <= 1'b0;
      r_pc    <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_mvi   <= 1'b0;
      r_wd    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_din   <= w_din_nxt;
      r_run   <= w_run_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
      r_mvi   <= w_mvi_nxt;
      r_wd    <= w_wd_nxt;
    end
  end

  // Next-state logic: Run is a one-cycle strobe, so it defaults low.
  always_comb begin
    w_state_nxt = r_state;
    w_din_nxt   = r_din;
    w_run_nxt   = 1'b0;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_mvi_nxt   = r_mvi;
    w_wd_nxt    = r_wd;
    unique case (r_state)
      S_IDLE, S_HALTED: begin
        if (Go) begin
          w_state_nxt = S_FETCH;
          w_pc_nxt    = '0;
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b0;
        end
      end
      S_FETCH: begin
        if (w_word[8:6] == OP_HALT) begin
          w_state_nxt = S_HALTED;
        end else if ((w_word[8:6] == OP_MVI) && (r_pc == AW'(DEPTH - 1))) begin
          // Immediate would lie past the end of the program store.
          w_state_nxt = S_HALTED;
          w_err_nxt   = 1'b1;
        end else begin
          w_din_nxt   = w_word;
          w_run_nxt   = 1'b1;
          w_mvi_nxt   = (w_word[8:6] == OP_MVI);
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // The immediate replaces the opcode word for the processor's step 1.
        if (r_mvi) begin
          w_din_nxt = w_imm;
        end
        w_wd_nxt    = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (Done) begin
          w_pc_nxt  = w_adv[AW-1:0];
          w_cnt_nxt = r_cnt + 16'd1;
          w_wd_nxt  = '0;
          if (w_adv[AW]) begin
            w_state_nxt = S_HALTED;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_FETCH;
          end
        end else if (w_wd_fire) begin
          w_state_nxt = S_HALTED;
          w_err_nxt   = 1'b1;
        end else begin
          w_wd_nxt = r_wd + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign DIN        = r_din;
  assign Run        = r_run;
  assign PC         = r_pc;
  assign InstrCount = r_cnt;
  assign Error      = r_err;
  assign Busy       = (r_state == S_FETCH) || (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign Halted     = (r_state == S_HALTED);

endmodule

// File: tb/tb_prog_feeder.sv
// Bench for prog_feeder: directed scenarios plus randomized programs and
// Done delays, compared against a program-level reference model.
module tb_prog_feeder;

  localparam int DEPTH   = 32;
  localparam int AW      = 5;
  localparam int TIMEOUT = 15;

  logic          Clock  = 1'b0;
  logic          Resetn = 1'b1;
  logic          Go     = 1'b0;
  logic          WrEn   = 1'b0;
  logic          Done   = 1'b0;
  logic [AW-1:0] WrAddr = '0;
  logic [15:0]   WrData = '0;
  logic [15:0]   DIN;
  logic          Run, Busy, Halted, Error;
  logic [AW-1:0] PC;
  logic [15:0]   InstrCount;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [15:0] shadow [DEPTH];
  int          dly_q[$];
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  int          m_pc, m_cnt;
  bit          m_err, m_carry;

  prog_feeder #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .Resetn(Resetn), .Go(Go), .WrEn(WrEn), .WrAddr(WrAddr),
    .WrData(WrData), .Done(Done), .DIN(DIN), .Run(Run), .Busy(Busy),
    .Halted(Halted), .Error(Error), .PC(PC), .InstrCount(InstrCount)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clock);
    cyc++;
  endtask

  task automatic load(input int a, input logic [15:0] d);
    WrEn = 1'b1; WrAddr = a[AW-1:0]; WrData = d;
    tick();
    WrEn = 1'b0;
    shadow[a] = d;
  endtask

  task automatic pulse_go();
    Go = 1'b1;
    tick();
    Go = 1'b0;
  endtask

  task automatic go_with_write(input int a, input logic [15:0] d);
    Go = 1'b1; WrEn = 1'b1; WrAddr = a[AW-1:0]; WrData = d;
    tick();
    Go = 1'b0; WrEn = 1'b0;
    shadow[a] = d;
  endtask

  task automatic fill_dly(input int d0);
    dly_q.delete();
    dly_q.push_back(d0);
    for (int i = 0; i < 40; i++) dly_q.push_back(1);
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    int r;
    w = 16'($urandom);
    r = $urandom_range(0, 19);
    if (r == 0)      w[8:6] = 3'b111;
    else if (r < 5)  w[8:6] = 3'b001;
    else begin
      w[8:6] = 3'($urandom_range(2, 7));
      if (w[8:6] == 3'b111) w[8:6] = 3'b000;
    end
    return w;
  endfunction

  // Reference: walk the program as the processor would see it.
  task automatic model_run();
    int pc, k;
    logic [15:0] w;
    bit mvi;
    exp_q.delete();
    m_cnt = 0; m_err = 0; m_carry = 0; pc = 0; k = 0;
    forever begin
      w = shadow[pc];
      mvi = (w[8:6] == 3'b001);
      if (w[8:6] == 3'b111) break;
      if (mvi && pc == DEPTH - 1) begin m_err = 1; break; end
      exp_q.push_back(w);
      if (mvi) exp_q.push_back(shadow[pc + 1]);
      if (dly_q[k] > TIMEOUT) begin m_err = 1; break; end
      k++;
      m_cnt++;
      pc += mvi ? 2 : 1;
      if (pc >= DEPTH) begin m_err = 1; m_carry = 1; pc -= DEPTH; break; end
    end
    m_pc = pc;
  endtask

  // Processor stand-in: records what is issued and answers with Done
  // after the queued number of WAIT cycles (or never, past TIMEOUT).
  task automatic respond(input int limit);
    int k, run_cyc, last_done, t0, d;
    bit mvi;
    logic [15:0] held;
    k = 0; last_done = -1; t0 = cyc;
    got_q.delete();
    while (!Halted) begin
      if (cyc - t0 > limit) begin
        check("halt_within_budget", Halted, 1);
        return;
      end
      tick();
      if (Run) begin
        run_cyc = cyc;
        if (last_done >= 0) check("done_to_run_lat", cyc - last_done, 2);
        else                check("go_to_run_lat", cyc - t0, 1);
        got_q.push_back(DIN);
        mvi = (DIN[8:6] == 3'b001);
        tick();
        check("run_one_cycle", Run, 0);
        if (mvi) got_q.push_back(DIN);
        held = DIN;
        d = dly_q[k];
        k++;
        if (d > TIMEOUT) begin
          while (!Halted && cyc - run_cyc <= TIMEOUT + 4) tick();
          check("watchdog_lat", cyc - run_cyc, TIMEOUT + 1);
        end else begin
          repeat (d - 1) tick();
          check("din_stable", DIN, held);
          Done = 1'b1;
          last_done = cyc;
          tick();
          Done = 1'b0;
        end
      end
    end
  endtask

  task automatic verify(input string tag);
    model_run();
    check({tag, "_nwords"}, got_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < got_q.size()) check({tag, "_word"}, got_q[i], exp_q[i]);
    check({tag, "_halted"}, Halted, 1);
    check({tag, "_error"}, Error, m_err);
    check({tag, "_count"}, InstrCount, m_cnt);
    if (!m_carry) check({tag, "_pc"}, PC, m_pc);
    check({tag, "_run"}, Run, 0);
    check({tag, "_busy"}, Busy, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_din"}, DIN, 0);
    check({tag, "_run"}, Run, 0);
    check({tag, "_busy"}, Busy, 0);
    check({tag, "_halted"}, Halted, 0);
    check({tag, "_error"}, Error, 0);
    check({tag, "_pc"}, PC, 0);
    check({tag, "_count"}, InstrCount, 0);
  endtask

  initial begin
    #1 Resetn = 1'b0;
    tick(); tick();
    check_reset_vals("rst");
    Resetn = 1'b1;
    tick();
    check_reset_vals("idle");

    // MV then HALT
    load(0, 16'h0008); load(1, 16'h01C0);
    fill_dly(1);
    pulse_go();
    respond(200);
    check("mv_nrun", got_q.size(), 1);
    check("mv_din", got_q[0], 16'h0008);
    check("mv_halted", Halted, 1);
    check("mv_pc", PC, 1);
    check("mv_count", InstrCount, 1);
    check("mv_error", Error, 0);
    verify("mv");

    // MVI with immediate, then HALT
    load(0, 16'h0040); load(1, 16'h1234); load(2, 16'h01C0);
    fill_dly(3);
    pulse_go();
    respond(200);
    check("mvi_op", got_q[0], 16'h0040);
    check("mvi_imm", got_q[1], 16'h1234);
    check("mvi_pc", PC, 2);
    check("mvi_count", InstrCount, 1);
    verify("mvi");

    // Watchdog, Go clears Error and reruns
    load(0, 16'h0081); load(1, 16'h01C0);
    fill_dly(99);
    pulse_go();
    respond(200);
    check("wd_error", Error, 1);
    check("wd_halted", Halted, 1);
    check("wd_pc", PC, 0);
    check("wd_count", InstrCount, 0);
    fill_dly(1);
    pulse_go();
    check("wd_err_clr", Error, 0);
    check("wd_pc_restart", PC, 0);
    respond(200);
    check("wd_rerun_count", InstrCount, 1);
    verify("wd_rerun");

    // Done on the TIMEOUT-th WAIT cycle beats the watchdog
    fill_dly(TIMEOUT);
    pulse_go();
    respond(200);
    check("wd_edge_error", Error, 0);
    verify("wd_edge");

    // MVI at the last address, then PC carry with no HALT
    for (int i = 0; i < DEPTH - 1; i++) load(i, 16'(i));
    load(DEPTH - 1, 16'h0040);
    fill_dly(1);
    pulse_go();
    respond(2000);
    check("mvi_end_error", Error, 1);
    check("mvi_end_count", InstrCount, DEPTH - 1);
    check("mvi_end_pc", PC, DEPTH - 1);
    verify("mvi_end");
    load(DEPTH - 1, 16'h001F);
    pulse_go();
    respond(2000);
    check("carry_count", InstrCount, DEPTH);
    check("carry_error", Error, 1);
    verify("carry");

    // Write and Go while busy are ignored
    load(0, 16'h0081); load(1, 16'h01C0);
    pulse_go();
    tick();
    check("busy_run", Run, 1);
    tick();
    WrEn = 1'b1; WrAddr = '0; WrData = 16'h01C0; Go = 1'b1;
    tick();
    WrEn = 1'b0; Go = 1'b0;
    check("busy_still", Busy, 1);
    check("busy_pc", PC, 0);
    Done = 1'b1;
    tick();
    Done = 1'b0;
    for (int i = 0; i < 5 && !Halted; i++) tick();
    check("busy_end_pc", PC, 1);
    check("busy_end_count", InstrCount, 1);
    fill_dly(1);
    pulse_go();
    respond(200);
    check("busy_mem_kept", got_q[0], 16'h0081);
    verify("busy_rerun");

    // Asynchronous reset during ISSUE
    pulse_go();
    tick();
    check("arst_run_pre", Run, 1);
    #1 Resetn = 1'b0;
    #1 check_reset_vals("arst");
    tick();
    Resetn = 1'b1;
    tick();
    fill_dly(2);
    pulse_go();
    respond(200);
    verify("arst_replay");

    // Random programs and Done delays; word 0 written together with Go
    for (int t = 0; t < 20; t++) begin
      for (int a = 0; a < DEPTH; a++) load(a, rand_word());
      dly_q.delete();
      for (int i = 0; i < 40; i++)
        dly_q.push_back(($urandom_range(0, 14) == 0) ? $urandom_range(TIMEOUT + 1, TIMEOUT + 3)
                                                     : $urandom_range(1, 8));
      go_with_write(0, rand_word());
      respond(3000);
      verify("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
